cache_line_xfer_ctrl: RTL and testbench

- Line-transfer sequencer between the cache data SRAM (four byte-lane cells) and main memory.
- The cache core pulses `start` on a miss. The block writes back the dirty victim line word-by-word (SRAM read, then memory write), then fills the new line word-by-word (memory read, then SRAM write). It pulses `done` at the end.
- While this block is busy, the cache core owns no SRAM or memory port.

---
 rtl/cache_pkg.sv | 22 ++
 rtl/cache_line_xfer_ctrl_if.sv | 31 +++
 rtl/phase_timer.sv | 30 +++
 rtl/cache_line_xfer_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_cache_line_xfer_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types, defaults and index helper for the line-transfer sequencer
package cache_pkg;

   typedef enum logic [2:0] {
      IDLE,
      WB_RD,
      WB_WR,
      FL_RD,
      FL_WR,
      DONE
   } xfer_state_t;

   localparam int DEF_LINE_WORDS   = 32;
   localparam int DEF_SRAM_LATENCY = 1;
   localparam int DEF_MEM_LATENCY  = 2;

   // Word offset within the line when the fill starts at word crit and wraps.
   function automatic int unsigned word_idx(int unsigned cnt, int unsigned crit, int unsigned n);
      return (cnt + crit) % n;
   endfunction

endpackage

// File: rtl/cache_line_xfer_ctrl_if.sv
// rtl/cache_line_xfer_ctrl_if.sv - data SRAM and main memory port bundle of the sequencer
interface cache_line_xfer_ctrl_if #(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int SRAM_ADDR_WIDTH = 12
);
   logic [SRAM_ADDR_WIDTH-1:0] sram_addr;
   logic                       sram_ren;
   logic                       sram_wen;
   logic [DATA_WIDTH-1:0]      sram_wdata;
   logic [DATA_WIDTH-1:0]      sram_rdata;
   logic [ADDR_WIDTH-1:0]      mem_addr;
   logic                       mem_ren;
   logic                       mem_wen;
   logic [DATA_WIDTH-1:0]      mem_din;
   logic [DATA_WIDTH-1:0]      mem_dout;

   modport master (
      output sram_addr, sram_ren, sram_wen, sram_wdata,
      input  sram_rdata,
      output mem_addr, mem_ren, mem_wen, mem_din,
      input  mem_dout
   );

   modport slave (
      input  sram_addr, sram_ren, sram_wen, sram_wdata,
      output sram_rdata,
      input  mem_addr, mem_ren, mem_wen, mem_din,
      output mem_dout
   );
endinterface

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - shared down-counter giving first/last-cycle flags of each transfer phase
module phase_timer #(
   parameter int WIDTH = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic             first,
   output logic             last
);
   logic [WIDTH-1:0] count;

   // A phase loaded with value L spans L+1 cycles; last is the cycle count reaches zero.
   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
         first <= 1'b0;
      end else if (load) begin
         count <= load_val;
         first <= 1'b1;
      end else begin
         first <= 1'b0;
         if (count != '0)
            count <= count - 1'b1;
      end
   end

   assign last = (count == '0);
endmodule

// File: rtl/cache_line_xfer_ctrl.sv
// rtl/cache_line_xfer_ctrl.sv - victim writeback and line fill sequencer; CACHE_CRITICAL_WORD_FIRST_EN wraps the fill from crit_word
module cache_line_xfer_ctrl
   import cache_pkg::*;
#(
   parameter int DATA_WIDTH      = 32,
   parameter int ADDR_WIDTH      = 32,
   parameter int SRAM_ADDR_WIDTH = 12,
   parameter int LINE_WORDS      = DEF_LINE_WORDS,
   parameter int SRAM_LATENCY    = DEF_SRAM_LATENCY,
   parameter int MEM_LATENCY     = DEF_MEM_LATENCY,
   localparam int CW             = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic                       wb_en,
   input  logic [ADDR_WIDTH-1:0]      victim_addr,
   input  logic [ADDR_WIDTH-1:0]      fill_addr,
   input  logic [SRAM_ADDR_WIDTH-1:0] sram_base,
   input  logic [CW-1:0]              crit_word,
   output logic                       busy,
   output logic                       done,
   output logic                       crit_valid,
   output logic [DATA_WIDTH-1:0]      crit_data,
   cache_line_xfer_ctrl_if.master     bus
);
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
   localparam bit CRIT_FIRST = 1'b1;
`else
   localparam bit CRIT_FIRST = 1'b0;
`endif

   localparam int MAXL = (SRAM_LATENCY > MEM_LATENCY) ? SRAM_LATENCY : MEM_LATENCY;
   localparam int TW   = (MAXL > 0) ? $clog2(MAXL + 1) : 1;
   localparam logic [TW-1:0] SLEN = TW'(SRAM_LATENCY);
   localparam logic [TW-1:0] MLEN = TW'(MEM_LATENCY);

   xfer_state_t                state;
   logic [CW-1:0]              cnt;
   logic [CW-1:0]              cnt_inc;
   logic                       last_word;
   logic [ADDR_WIDTH-1:0]      victim_q;
   logic [ADDR_WIDTH-1:0]      fill_q;
   logic [SRAM_ADDR_WIDTH-1:0] base_q;
   logic [CW-1:0]              crit_q;
   logic [DATA_WIDTH-1:0]      word_q;
   logic [SRAM_ADDR_WIDTH-1:0] sram_addr_q;
   logic                       sram_ren_q;
   logic                       sram_wen_q;
   logic [ADDR_WIDTH-1:0]      mem_addr_q;
   logic                       mem_ren_q;
   logic                       mem_wen_q;
   logic                       tmr_load;
   logic [TW-1:0]              tmr_len;
   logic                       tmr_first;
   logic                       tmr_last;

   function automatic logic [CW-1:0] fill_idx(logic [CW-1:0] c, logic [CW-1:0] k);
      return CW'(word_idx(32'(c), CRIT_FIRST ? 32'(k) : 32'd0, LINE_WORDS));
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] mem_word_addr(logic [ADDR_WIDTH-1:0] b, logic [CW-1:0] w);
      return b + (ADDR_WIDTH'(w) << 2);
   endfunction

   function automatic logic [SRAM_ADDR_WIDTH-1:0] sram_word_addr(logic [SRAM_ADDR_WIDTH-1:0] b,
                                                                 logic [CW-1:0] w);
      return b + SRAM_ADDR_WIDTH'(w);
   endfunction

   assign cnt_inc   = cnt + 1'b1;
   assign last_word = (cnt == CW'(LINE_WORDS - 1));

   phase_timer #(.WIDTH(TW)) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (tmr_load),
      .load_val (tmr_len),
      .first    (tmr_first),
      .last     (tmr_last)
   );

   // Timer reload mirrors the phase transitions below; DONE needs no timing.
   always_comb begin
      tmr_load = 1'b0;
      tmr_len  = '0;
      case (state)
         IDLE:  if (start) begin
                   tmr_load = 1'b1;
                   tmr_len  = wb_en ? SLEN : MLEN;
                end
         WB_RD: if (tmr_last) begin
                   tmr_load = 1'b1;
                   tmr_len  = MLEN;
                end
         WB_WR: if (tmr_last) begin
                   tmr_load = 1'b1;
                   tmr_len  = last_word ? MLEN : SLEN;
                end
         FL_RD: if (tmr_last) begin
                   tmr_load = 1'b1;
                   tmr_len  = SLEN;
                end
         FL_WR: if (tmr_last && !last_word) begin
                   tmr_load = 1'b1;
                   tmr_len  = MLEN;
                end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         victim_q    <= '0;
         fill_q      <= '0;
         base_q      <= '0;
         crit_q      <= '0;
         word_q      <= '0;
         sram_addr_q <= '0;
         sram_ren_q  <= 1'b0;
         sram_wen_q  <= 1'b0;
         mem_addr_q  <= '0;
         mem_ren_q   <= 1'b0;
         mem_wen_q   <= 1'b0;
      end else begin
         done <= 1'b0;
         // Strobes live only in a phase's first cycle; a new phase may re-arm one below.
         if (tmr_first) begin
            sram_ren_q <= 1'b0;
            sram_wen_q <= 1'b0;
            mem_ren_q  <= 1'b0;
            mem_wen_q  <= 1'b0;
         end
         case (state)
            IDLE: if (start) begin
               victim_q <= victim_addr;
               fill_q   <= fill_addr;
               base_q   <= sram_base;
               crit_q   <= crit_word;
               cnt      <= '0;
               busy     <= 1'b1;
               if (wb_en) begin
                  state       <= WB_RD;
                  sram_addr_q <= sram_base;
                  sram_ren_q  <= 1'b1;
               end else begin
                  state      <= FL_RD;
                  mem_addr_q <= mem_word_addr(fill_addr, fill_idx('0, crit_word));
                  mem_ren_q  <= 1'b1;
               end
            end
            WB_RD: if (tmr_last) begin
               word_q     <= bus.sram_rdata;
               state      <= WB_WR;
               mem_addr_q <= mem_word_addr(victim_q, cnt);
               mem_wen_q  <= 1'b1;
            end
            WB_WR: if (tmr_last) begin
               if (last_word) begin
                  cnt        <= '0;
                  state      <= FL_RD;
                  mem_addr_q <= mem_word_addr(fill_q, fill_idx('0, crit_q));
                  mem_ren_q  <= 1'b1;
               end else begin
                  cnt         <= cnt_inc;
                  state       <= WB_RD;
                  sram_addr_q <= sram_word_addr(base_q, cnt_inc);
                  sram_ren_q  <= 1'b1;
               end
            end
            FL_RD: if (tmr_last) begin
               word_q      <= bus.mem_dout;
               state       <= FL_WR;
               sram_addr_q <= sram_word_addr(base_q, fill_idx(cnt, crit_q));
               sram_wen_q  <= 1'b1;
            end
            FL_WR: if (tmr_last) begin
               if (last_word) begin
                  state <= DONE;
                  done  <= 1'b1;
               end else begin
                  cnt        <= cnt_inc;
                  state      <= FL_RD;
                  mem_addr_q <= mem_word_addr(fill_q, fill_idx(cnt_inc, crit_q));
                  mem_ren_q  <= 1'b1;
               end
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
               cnt   <= '0;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // The first fill word is the only FL_RD with cnt at zero.
   assign crit_valid = CRIT_FIRST && (state == FL_RD) && (cnt == '0) && tmr_last;
   assign crit_data  = crit_valid ? bus.mem_dout : '0;

   assign bus.sram_addr  = sram_addr_q;
   assign bus.sram_ren   = sram_ren_q;
   assign bus.sram_wen   = sram_wen_q;
   assign bus.sram_wdata = word_q;
   assign bus.mem_addr   = mem_addr_q;
   assign bus.mem_ren    = mem_ren_q;
   assign bus.mem_wen    = mem_wen_q;
   assign bus.mem_din    = word_q;
endmodule

// File: tb/tb_cache_line_xfer_ctrl.sv
// tb/tb_cache_line_xfer_ctrl.sv - randomized bench for the line-transfer sequencer against a cycle-schedule model
module tb_cache_line_xfer_ctrl;
   localparam int SL = 1;
   localparam int ML = 2;
   localparam int P  = SL + ML + 2;
`ifdef CACHE_CRITICAL_WORD_FIRST_EN
   localparam bit CWF = 1'b1;
`else
   localparam bit CWF = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_a = 1'b0;
   logic        start_b = 1'b0;
   logic        wb_en = 1'b0;
   logic [31:0] victim_addr = '0;
   logic [31:0] fill_addr = '0;
   logic [11:0] sram_base = '0;
   logic [1:0]  crit_word = '0;
   logic        sel_b = 1'b0;

   logic        a_busy, a_done, a_cv, b_busy, b_done, b_cv;
   logic [31:0] a_cd, b_cd;
   logic [31:0] sram_rdata, mem_dout;

   int checks = 0;
   int errors = 0;

   cache_line_xfer_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SRAM_ADDR_WIDTH(12)) bus_a ();
   cache_line_xfer_ctrl_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SRAM_ADDR_WIDTH(12)) bus_b ();

   cache_line_xfer_ctrl #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .SRAM_ADDR_WIDTH(12),
      .LINE_WORDS(4), .SRAM_LATENCY(SL), .MEM_LATENCY(ML)
   ) dut_a (
      .clk(clk), .rst(rst), .start(start_a), .wb_en(wb_en),
      .victim_addr(victim_addr), .fill_addr(fill_addr), .sram_base(sram_base),
      .crit_word(crit_word), .busy(a_busy), .done(a_done),
      .crit_valid(a_cv), .crit_data(a_cd), .bus(bus_a)
   );

   cache_line_xfer_ctrl #(
      .DATA_WIDTH(32), .ADDR_WIDTH(32), .SRAM_ADDR_WIDTH(12),
      .LINE_WORDS(1), .SRAM_LATENCY(SL), .MEM_LATENCY(ML)
   ) dut_b (
      .clk(clk), .rst(rst), .start(start_b), .wb_en(wb_en),
      .victim_addr(victim_addr), .fill_addr(fill_addr), .sram_base(sram_base),
      .crit_word(crit_word[0]), .busy(b_busy), .done(b_done),
      .crit_valid(b_cv), .crit_data(b_cd), .bus(bus_b)
   );

   always #5 clk = ~clk;

   // Outputs of whichever instance is under test.
   logic [11:0] c_sram_addr;
   logic        c_sram_ren, c_sram_wen, c_mem_ren, c_mem_wen, c_busy, c_done, c_cv;
   logic [31:0] c_sram_wdata, c_mem_addr, c_mem_din, c_cd;
   logic [255:0] c_all;

   assign c_sram_addr  = sel_b ? bus_b.sram_addr  : bus_a.sram_addr;
   assign c_sram_ren   = sel_b ? bus_b.sram_ren   : bus_a.sram_ren;
   assign c_sram_wen   = sel_b ? bus_b.sram_wen   : bus_a.sram_wen;
   assign c_sram_wdata = sel_b ? bus_b.sram_wdata : bus_a.sram_wdata;
   assign c_mem_addr   = sel_b ? bus_b.mem_addr   : bus_a.mem_addr;
   assign c_mem_ren    = sel_b ? bus_b.mem_ren    : bus_a.mem_ren;
   assign c_mem_wen    = sel_b ? bus_b.mem_wen    : bus_a.mem_wen;
   assign c_mem_din    = sel_b ? bus_b.mem_din    : bus_a.mem_din;
   assign c_busy       = sel_b ? b_busy : a_busy;
   assign c_done       = sel_b ? b_done : a_done;
   assign c_cv         = sel_b ? b_cv   : a_cv;
   assign c_cd         = sel_b ? b_cd   : a_cd;
   assign c_all = 256'({c_sram_addr, c_sram_ren, c_sram_wen, c_sram_wdata, c_mem_addr, c_mem_ren,
                        c_mem_wen, c_mem_din, c_busy, c_done, c_cv, c_cd});

   assign bus_a.sram_rdata = sram_rdata;
   assign bus_b.sram_rdata = sram_rdata;
   assign bus_a.mem_dout   = mem_dout;
   assign bus_b.mem_dout   = mem_dout;

   function automatic logic [31:0] mem_word(logic [31:0] a);
      return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
   endfunction

   // SRAM and memory devices: read data valid only on its latency cycle, junk otherwise.
   logic [31:0] sram_m [0:4095];
   logic        m_v1 = 1'b0;
   logic [31:0] m_a1 = '0;
   always @(posedge clk) begin
      sram_rdata <= c_sram_ren ? sram_m[c_sram_addr] : $urandom;
      if (c_sram_wen) sram_m[c_sram_addr] = c_sram_wdata;
      m_v1     <= c_mem_ren;
      m_a1     <= c_mem_addr;
      mem_dout <= m_v1 ? mem_word(m_a1) : $urandom;
   end

   task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive_start(input bit b, input logic s);
      if (b) start_b = s;
      else   start_a = s;
   endtask

   // One transfer; every cycle's strobes, addresses and data come from the schedule arithmetic.
   task automatic run_xfer(input bit b, input int lw, input bit wb, input logic [31:0] va,
                           input logic [31:0] fa, input logic [11:0] sb, input logic [1:0] cw,
                           input bit hold, input int rst_at);
      int f0, d, o, i, j, w;
      logic [31:0] snap [0:3];
      logic [11:0] sa;
      bit e_sr, e_sw, e_mr, e_mw, e_cv;
      sel_b = b;
      for (int n = 0; n < lw; n++) begin
         sa = sb + 12'(n);
         snap[n] = sram_m[sa];
      end
      @(negedge clk);
      wb_en = wb; victim_addr = va; fill_addr = fa; sram_base = sb; crit_word = cw;
      drive_start(b, 1'b1);
      f0 = 1 + (wb ? lw * P : 0);
      d  = f0 + lw * P;
      for (int k = 1; k <= d + 1; k++) begin
         @(negedge clk);
         e_sr = 0; e_sw = 0; e_mr = 0; e_mw = 0; e_cv = 0; w = 0;
         if (k >= 1 && k < f0) begin
            i = (k - 1) / P; o = (k - 1) % P;
            if (o < SL + 1) begin
               e_sr = (o == 0);
               check_eq("wb_sram_addr", 256'(c_sram_addr), 256'(sb + 12'(i)));
            end else begin
               e_mw = (o == SL + 1);
               check_eq("wb_mem_addr", 256'(c_mem_addr), 256'(va + 32'(4 * i)));
               check_eq("wb_mem_din", 256'(c_mem_din), 256'(snap[i]));
            end
         end else if (k >= f0 && k < d) begin
            j = (k - f0) / P; o = (k - f0) % P;
            w = CWF ? (int'(cw) + j) % lw : j;
            if (o < ML + 1) begin
               e_mr = (o == 0);
               e_cv = CWF && (j == 0) && (o == ML);
               check_eq("fl_mem_addr", 256'(c_mem_addr), 256'(fa + 32'(4 * w)));
            end else begin
               e_sw = (o == ML + 1);
               check_eq("fl_sram_addr", 256'(c_sram_addr), 256'(sb + 12'(w)));
               check_eq("fl_sram_wdata", 256'(c_sram_wdata), 256'(mem_word(fa + 32'(4 * w))));
            end
         end
         check_eq($sformatf("ctl_c%0d", k),
                  256'({c_sram_ren, c_sram_wen, c_mem_ren, c_mem_wen, c_done, c_busy, c_cv}),
                  256'({e_sr, e_sw, e_mr, e_mw, k == d, k <= d, e_cv}));
         check_eq("crit_data", 256'(c_cd), e_cv ? 256'(mem_word(fa + 32'(4 * w))) : 256'(0));
         wb_en = 1'($urandom); victim_addr = $urandom; fill_addr = $urandom;
         sram_base = 12'($urandom); crit_word = 2'($urandom);
         drive_start(b, hold && (k <= d));
         if (k == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            check_eq("rst_mid_outputs", c_all, 256'(0));
            rst = 1'b0;
            repeat (20) begin
               @(negedge clk);
               check_eq("post_rst_quiet", c_all, 256'(0));
            end
            return;
         end
      end
      drive_start(b, 1'b0);
   endtask

   initial begin
      bit          rb, rwb, rhold;
      int          rlw;
      logic [31:0] rva, rfa;
      logic [11:0] rsb;
      logic [1:0]  rcw;
      for (int n = 0; n < 4096; n++) sram_m[n] = $urandom;
      repeat (3) @(negedge clk);
      sel_b = 1'b0; #1;
      check_eq("reset_a", c_all, 256'(0));
      sel_b = 1'b1; #1;
      check_eq("reset_b", c_all, 256'(0));
      rst = 1'b0;

      run_xfer(0, 4, 0, 32'h2000, 32'h1000, 12'h040, 2'd0, 0, -1);
      for (int n = 0; n < 4; n++) sram_m[12'h040 + n] = 32'hA0 + 32'(n);
      run_xfer(0, 4, 1, 32'h2000, 32'h1000, 12'h040, 2'd0, 0, -1);
      run_xfer(0, 4, 0, 32'h2000, 32'h1000, 12'h040, 2'd2, 0, -1);
      run_xfer(0, 4, 1, 32'h2000, 32'h1000, 12'h080, 2'd1, 1, -1);
      run_xfer(0, 4, 0, 32'h2000, 32'h1000, 12'h040, 2'd0, 0, 12);
      run_xfer(1, 1, 1, 32'h3000, 32'h4000, 12'h100, 2'd0, 0, -1);

      for (int n = 0; n < 24; n++) begin
         rb    = 1'($urandom);
         rlw   = rb ? 1 : 4;
         rwb   = 1'($urandom);
         rhold = 1'($urandom);
         rva   = $urandom & 32'hFFFF_FF80;
         rfa   = $urandom & 32'hFFFF_FF80;
         rsb   = 12'($urandom) & 12'hFFC;
         rcw   = rb ? 2'd0 : 2'($urandom_range(0, 3));
         run_xfer(rb, rlw, rwb, rva, rfa, rsb, rcw, rhold, -1);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
